// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if: control bundle between the sequencer and the MIPS datapath.
//   Datapath -> sequencer: en, opcode, funct, zero
//   Sequencer -> datapath: state, stage strobes, mux selects, retire/illegal pulses, instr_cnt
// master = datapath side (drives decode inputs), slave = sequencer side.
interface mc_sequencer_if;
  logic        en;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic [2:0]  state;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        ir_we;
  logic        rf_re;
  logic        alu_en;
  logic [1:0]  alu_op;
  logic        alu_src_b;
  logic        dmem_we;
  logic        rf_we;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        instr_done;
  logic        illegal;
  logic [31:0] instr_cnt;

  modport master (
    output en, opcode, funct, zero,
    input  state, pc_we, pc_src, ir_we, rf_re, alu_en, alu_op, alu_src_b,
           dmem_we, rf_we, reg_dst, mem_to_reg, instr_done, illegal, instr_cnt
  );

  modport slave (
    input  en, opcode, funct, zero,
    output state, pc_we, pc_src, ir_we, rf_re, alu_en, alu_op, alu_src_b,
           dmem_we, rf_we, reg_dst, mem_to_reg, instr_done, illegal, instr_cnt
  );
endinterface

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control FSM for the single-issue MIPS datapath.
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : mc_sequencer_if.slave (en/opcode/funct/zero in; state, strobes,
//              selects, instr_done, illegal, instr_cnt out)
// Stages IF -> ID -> EX -> [MEM] -> [WB]; memory read latency is absorbed by a
// 3-bit wait counter that clears on every state entry. Strobes are decoded from
// the registered state/counter and the IR fields, one cycle wide each.
module mc_sequencer #(
  parameter int unsigned IMEM_LAT = 1,
  parameter int unsigned DMEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mc_sequencer_if.slave bus
);

  localparam int unsigned WCNT_W   = 3;
  localparam int unsigned CNT_W    = 32;
  localparam logic [WCNT_W-1:0] IMEM_LAST = WCNT_W'(IMEM_LAT);
  localparam logic [WCNT_W-1:0] DMEM_LAST = WCNT_W'(DMEM_LAT);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    instr_cnt_q, instr_cnt_d;

  logic       pc_we_c, ir_we_c, rf_re_c, alu_en_c, alu_src_b_c;
  logic       dmem_we_c, rf_we_c, reg_dst_c, mem_to_reg_c;
  logic       instr_done_c, illegal_c;
  logic [1:0] pc_src_c, alu_op_c;

  // State, wait counter and retire counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IF;
      wcnt_q      <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Next-state and strobe decode; leaving a state always clears the wait counter
  always_comb begin
    state_d      = S_IF;
    wcnt_d       = '0;
    pc_we_c      = 1'b0;
    pc_src_c     = 2'b00;
    ir_we_c      = 1'b0;
    rf_re_c      = 1'b0;
    alu_en_c     = 1'b0;
    alu_op_c     = 2'b00;
    alu_src_b_c  = 1'b0;
    dmem_we_c    = 1'b0;
    rf_we_c      = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;

    case (state_q)
      S_IF: begin
        // en only matters before a fetch has started
        if (wcnt_q == '0 && !bus.en) begin
          state_d = S_IF;
        end else if (wcnt_q == IMEM_LAST) begin
          ir_we_c  = 1'b1;
          pc_we_c  = 1'b1;
          pc_src_c = 2'b00;
          state_d  = S_ID;
        end else begin
          state_d = S_IF;
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end

      S_ID: begin
        rf_re_c = 1'b1;
        case (bus.opcode)
          OP_J: begin
            pc_we_c      = 1'b1;
            pc_src_c     = 2'b10;
            instr_done_c = 1'b1;
          end
          OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
            state_d = S_EX;
          end
          default: begin
            // PC was already advanced in IF, so execution resumes at PC+4
            illegal_c    = 1'b1;
            instr_done_c = 1'b1;
          end
        endcase
      end

      S_EX: begin
        alu_en_c = 1'b1;
        case (bus.opcode)
          OP_RTYPE: begin
            alu_op_c = 2'b10;
            state_d  = S_WB;
          end
          OP_ADDI: begin
            alu_src_b_c = 1'b1;
            state_d     = S_WB;
          end
          OP_ORI: begin
            alu_op_c    = 2'b11;
            alu_src_b_c = 1'b1;
            state_d     = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b_c = 1'b1;
            state_d     = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            // Subtract to compare; bne takes the branch on a non-zero result
            alu_op_c     = 2'b01;
            pc_src_c     = 2'b01;
            pc_we_c      = bus.zero ^ (bus.opcode == OP_BNE);
            instr_done_c = 1'b1;
          end
          default: state_d = S_IF;
        endcase
      end

      S_MEM: begin
        if (bus.opcode == OP_SW) begin
          dmem_we_c    = 1'b1;
          instr_done_c = 1'b1;
        end else if (wcnt_q == DMEM_LAST) begin
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end

      S_WB: begin
        rf_we_c      = 1'b1;
        reg_dst_c    = (bus.opcode == OP_RTYPE);
        mem_to_reg_c = (bus.opcode == OP_LW);
        instr_done_c = 1'b1;
      end

      default: state_d = S_IF;
    endcase

    instr_cnt_d = instr_cnt_q + CNT_W'(instr_done_c);
  end

  assign bus.state      = state_q;
  assign bus.pc_we      = pc_we_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.ir_we      = ir_we_c;
  assign bus.rf_re      = rf_re_c;
  assign bus.alu_en     = alu_en_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.dmem_we    = dmem_we_c;
  assign bus.rf_we      = rf_we_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.instr_done = instr_done_c;
  assign bus.illegal    = illegal_c;
  assign bus.instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed bench for mc_sequencer. A stage-schedule model
// expands each instruction into its expected per-cycle outputs; one compare
// process checks both DUT instances (DMEM_LAT=1 and DMEM_LAT=3) every cycle.
module tb_mc_sequencer;

  localparam int unsigned IL   = 1;
  localparam int unsigned DL_A = 1;
  localparam int unsigned DL_B = 3;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       rf_re;
    logic       alu_en;
    logic [1:0] alu_op;
    logic       alu_src_b;
    logic       dmem_we;
    logic       rf_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;
  } obs_t;

  typedef struct {
    obs_t        v;
    obs_t        m;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  mc_sequencer_if ifa ();
  mc_sequencer_if ifb ();

  mc_sequencer #(.IMEM_LAT(IL), .DMEM_LAT(DL_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  mc_sequencer #(.IMEM_LAT(IL), .DMEM_LAT(DL_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  obs_t act_a, act_b;
  assign act_a = {ifa.state, ifa.pc_we, ifa.pc_src, ifa.ir_we, ifa.rf_re, ifa.alu_en,
                  ifa.alu_op, ifa.alu_src_b, ifa.dmem_we, ifa.rf_we, ifa.reg_dst,
                  ifa.mem_to_reg, ifa.instr_done, ifa.illegal};
  assign act_b = {ifb.state, ifb.pc_we, ifb.pc_src, ifb.ir_we, ifb.rf_re, ifb.alu_en,
                  ifb.alu_op, ifb.alu_src_b, ifb.dmem_we, ifb.rf_we, ifb.reg_dst,
                  ifb.mem_to_reg, ifb.instr_done, ifb.illegal};

  exp_t qa[$], qb[$], scr_a[$], scr_b[$];
  exp_t ea, eb, ep;
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] cnt_a = 0;
  logic [31:0] cnt_b = 0;

  // Entry with every strobe cared for (expected 0) and selects don't-care
  function automatic exp_t base(input logic [2:0] st, input string tag);
    exp_t e;
    e.v = '0;
    e.m = '0;
    e.m.state = 3'h7; e.m.pc_we = 1'b1; e.m.ir_we = 1'b1; e.m.rf_re = 1'b1;
    e.m.alu_en = 1'b1; e.m.dmem_we = 1'b1; e.m.rf_we = 1'b1;
    e.m.instr_done = 1'b1; e.m.illegal = 1'b1;
    e.v.state = st;
    e.cnt = 0;
    e.tag = tag;
    return e;
  endfunction

  // Expand one instruction into its expected stage schedule
  task automatic gen(input int which, input logic [5:0] op, input logic zero, input int dlat);
    exp_t e;
    exp_t s[$];
    bit legal;
    legal = op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
    for (int i = 0; i <= int'(IL); i++) begin
      e = base(3'd0, "IF");
      if (i == int'(IL)) begin
        e.v.ir_we = 1'b1; e.v.pc_we = 1'b1; e.v.pc_src = 2'b00; e.m.pc_src = 2'b11;
      end
      s.push_back(e);
    end
    e = base(3'd1, "ID");
    e.v.rf_re = 1'b1;
    if (op == 6'h02) begin
      e.v.pc_we = 1'b1; e.v.pc_src = 2'b10; e.m.pc_src = 2'b11; e.v.instr_done = 1'b1;
    end else if (!legal) begin
      e.v.illegal = 1'b1; e.v.instr_done = 1'b1;
    end
    s.push_back(e);
    if (legal && op != 6'h02) begin
      e = base(3'd2, "EX");
      e.v.alu_en = 1'b1; e.m.alu_op = 2'b11; e.m.alu_src_b = 1'b1;
      case (op)
        6'h00:               begin e.v.alu_op = 2'b10; e.v.alu_src_b = 1'b0; end
        6'h08, 6'h23, 6'h2B: begin e.v.alu_op = 2'b00; e.v.alu_src_b = 1'b1; end
        6'h0D:               begin e.v.alu_op = 2'b11; e.v.alu_src_b = 1'b1; end
        default: begin
          e.v.alu_op = 2'b01; e.v.alu_src_b = 1'b0;
          e.v.pc_src = 2'b01; e.m.pc_src = 2'b11;
          e.v.pc_we = (op == 6'h04) ? zero : !zero;
          e.v.instr_done = 1'b1;
        end
      endcase
      s.push_back(e);
      if (op == 6'h2B) begin
        e = base(3'd3, "MEM");
        e.v.dmem_we = 1'b1; e.v.instr_done = 1'b1;
        s.push_back(e);
      end else if (op == 6'h23) begin
        for (int i = 0; i <= dlat; i++) s.push_back(base(3'd3, "MEM"));
      end
      if (op inside {6'h00, 6'h08, 6'h0D, 6'h23}) begin
        e = base(3'd4, "WB");
        e.v.rf_we = 1'b1; e.v.instr_done = 1'b1;
        e.v.reg_dst = (op == 6'h00); e.v.mem_to_reg = (op == 6'h23);
        e.m.reg_dst = 1'b1; e.m.mem_to_reg = 1'b1;
        s.push_back(e);
      end
    end
    if (which == 0) scr_a = s; else scr_b = s;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input obs_t act, input logic [31:0] cnt);
    n_checks++;
    if (((act ^ e.v) & e.m) !== '0) begin
      n_fail++;
      $display("FAIL %s %s outputs @%0t: got %05h, expected %05h (mask %05h)",
               who, e.tag, $time, act, e.v, e.m);
    end
    n_checks++;
    if (cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL %s %s instr_cnt @%0t: got %0h, expected %0h", who, e.tag, $time, cnt, e.cnt);
    end
  endtask

  // Single compare process: one expected entry per DUT per cycle, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin ea = qa.pop_front(); cmp("A", ea, act_a, ifa.instr_cnt); end
      if (qb.size() > 0) begin eb = qb.pop_front(); cmp("B", eb, act_b, ifb.instr_cnt); end
    end
  end

  // Queue this cycle's expectation, then advance to the next cycle start
  task automatic push_a(input exp_t e);
    exp_t x;
    x = e;
    x.cnt = cnt_a;
    if (x.v.instr_done) cnt_a = cnt_a + 32'd1;
    qa.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [5:0] op, input logic [5:0] fn, input logic zero, input int drop_at);
    ifa.opcode = op;
    ifa.funct  = fn;
    ifa.zero   = zero;
    gen(0, op, zero, int'(DL_A));
    foreach (scr_a[i]) begin
      if (i == drop_at) ifa.en = 1'b0;
      push_a(scr_a[i]);
    end
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) push_a(base(3'd0, "IDLE"));
  endtask

  // DUT B: a fixed stream of lw with the longer data latency after first reset release
  initial begin
    ifb.en = 1'b1; ifb.opcode = 6'h23; ifb.funct = 6'h00; ifb.zero = 1'b0;
    @(posedge reset_n);
    for (int k = 0; k < 2; k++) begin
      gen(1, 6'h23, 1'b0, int'(DL_B));
      foreach (scr_b[i]) begin
        eb = scr_b[i];
        eb.cnt = cnt_b;
        if (eb.v.instr_done) cnt_b = cnt_b + 32'd1;
        qb.push_back(eb);
        @(posedge clk);
        #1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ifa.en = 1'b1; ifa.opcode = 6'h00; ifa.funct = 6'h20; ifa.zero = 1'b0;

    // Pin the model's schedule lengths and retire points to hand-computed values
    gen(0, 6'h00, 1'b0, int'(DL_A)); chk("len_rtype", 32'(scr_a.size()), 32'd5);
    chk("rtype_done_c5", 32'(scr_a[4].v.instr_done), 32'd1);
    chk("rtype_regdst", 32'(scr_a[4].v.reg_dst), 32'd1);
    gen(0, 6'h23, 1'b0, int'(DL_A)); chk("len_lw", 32'(scr_a.size()), 32'd7);
    chk("lw_memtoreg", 32'(scr_a[6].v.mem_to_reg), 32'd1);
    gen(1, 6'h23, 1'b0, int'(DL_B)); chk("len_lw_dlat3", 32'(scr_b.size()), 32'd9);
    gen(0, 6'h2B, 1'b0, int'(DL_A)); chk("len_sw", 32'(scr_a.size()), 32'd5);
    gen(0, 6'h04, 1'b1, int'(DL_A)); chk("len_beq", 32'(scr_a.size()), 32'd4);
    chk("beq_taken", 32'(scr_a[3].v.pc_we), 32'd1);
    gen(0, 6'h05, 1'b1, int'(DL_A)); chk("bne_z1_not_taken", 32'(scr_a[3].v.pc_we), 32'd0);
    gen(0, 6'h02, 1'b0, int'(DL_A)); chk("len_j", 32'(scr_a.size()), 32'd3);
    gen(0, 6'h3F, 1'b0, int'(DL_A)); chk("len_illegal", 32'(scr_a.size()), 32'd3);

    @(posedge clk); #1;
    cnt_a = 0;
    push_a(base(3'd0, "RST"));
    push_a(base(3'd0, "RST"));
    reset_n = 1'b1;

    run_a(6'h00, 6'h20, 1'b0, -1);
    chk("cnt_after_first_r", ifa.instr_cnt, 32'd1);
    run_a(6'h23, 6'h00, 1'b0, -1);
    run_a(6'h04, 6'h00, 1'b1, -1);
    run_a(6'h04, 6'h00, 1'b0, -1);
    run_a(6'h05, 6'h00, 1'b0, -1);
    run_a(6'h05, 6'h00, 1'b1, -1);
    run_a(6'h2B, 6'h00, 1'b0, -1);
    run_a(6'h3F, 6'h00, 1'b0, -1);
    run_a(6'h02, 6'h00, 1'b0, -1);
    run_a(6'h08, 6'h00, 1'b0, -1);
    run_a(6'h0D, 6'h00, 1'b0, -1);
    chk("cnt_after_eleven", ifa.instr_cnt, 32'd11);

    // en dropped during EX: instruction retires, then IF holds until en returns
    run_a(6'h00, 6'h22, 1'b0, 3);
    idle_a(3);
    ifa.en = 1'b1;
    run_a(6'h00, 6'h25, 1'b0, -1);

    // Reset asserted in the lw data-wait cycle
    ifa.opcode = 6'h23; ifa.zero = 1'b0;
    gen(0, 6'h23, 1'b0, int'(DL_A));
    for (int i = 0; i < 5; i++) push_a(scr_a[i]);
    reset_n = 1'b0;
    #1;
    chk("rst_state", 32'(ifa.state), 32'd0);
    chk("rst_cnt", ifa.instr_cnt, 32'd0);
    chk("rst_strobes", 32'({ifa.pc_we, ifa.ir_we, ifa.rf_re, ifa.alu_en, ifa.dmem_we,
                            ifa.rf_we, ifa.instr_done, ifa.illegal}), 32'd0);
    cnt_a = 0;
    push_a(base(3'd0, "RST"));
    push_a(base(3'd0, "RST"));
    reset_n = 1'b1;
    run_a(6'h00, 6'h20, 1'b0, -1);
    chk("cnt_after_reset_r", ifa.instr_cnt, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("queues_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
